// File: rtl/phys_free_list.sv
// phys_free_list: physical-register free list for the REMAP build.
// Circular FIFO of free physical tags with a speculative head (rename),
// a committed head (retire) and a tail (reclaim). FLUSH rolls the
// speculative head back to the committed head.
// Optional checking: define FREELIST_CHECK_EN to enable the sticky
// protocol-error flag `err`; otherwise `err` is tied low.
module phys_free_list #(
   parameter int PHYS_REGS = 64,
   parameter int ARCH_REGS = 32,
   parameter int TAG_W     = 6,
   parameter int LOW_WATER = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             STALL,
   input  logic             FLUSH,
   input  logic             alloc_req,
   output logic             rrat_free,
   output logic [TAG_W-1:0] rrat_free_reg,
   input  logic             commit_alloc,
   input  logic             release_valid,
   input  logic [TAG_W-1:0] release_reg,
   output logic [TAG_W:0]   free_count,
   output logic             halt,
   output logic             err
);

   localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

   logic [TAG_W-1:0] mem_q [PHYS_REGS];
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] chead_q, chead_d;
   logic [TAG_W-1:0] tail_q, tail_d;

   logic empty, full, alloc_fire, rel_fire;

   // Occupancy never exceeds FREE_INIT < PHYS_REGS, so a plain pointer
   // difference distinguishes full from empty.
   assign free_count    = {1'b0, tail_q - head_q};
   assign empty         = (free_count == '0);
   assign full          = (free_count == (TAG_W+1)'(FREE_INIT));
   assign rrat_free     = ~empty;
   assign rrat_free_reg = mem_q[head_q];
   assign halt          = (free_count <= (TAG_W+1)'(LOW_WATER));

   // Release is architectural: not gated by STALL/FLUSH; tag 0 is r0 and dropped.
   assign alloc_fire = alloc_req & rrat_free & ~STALL & ~FLUSH;
   assign rel_fire   = release_valid & (release_reg != '0) & ~full;

   // Next-state pointers; FLUSH wins over allocate and folds in a same-cycle commit.
   always_comb begin
      head_d  = head_q;
      chead_d = chead_q + TAG_W'(commit_alloc);
      tail_d  = tail_q;
      if (FLUSH)
         head_d = chead_q + TAG_W'(commit_alloc);
      else if (alloc_fire)
         head_d = head_q + TAG_W'(1);
      if (rel_fire)
         tail_d = tail_q + TAG_W'(1);
   end

   // Pointer registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head_q  <= '0;
         chead_q <= '0;
         tail_q  <= TAG_W'(FREE_INIT);
      end else begin
         head_q  <= head_d;
         chead_q <= chead_d;
         tail_q  <= tail_d;
      end
   end

   // Tag storage: unmapped tags ARCH_REGS.. preloaded, reclaimed tags written at tail.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < PHYS_REGS; i++)
            mem_q[i] <= (i < FREE_INIT) ? TAG_W'(ARCH_REGS + i) : '0;
      end else if (rel_fire) begin
         mem_q[tail_q] <= release_reg;
      end
   end

`ifdef FREELIST_CHECK_EN
   logic             dup;
   logic             e_empty, e_ovf, e_commit, e_dup;
   logic             err_q;
   logic [TAG_W-1:0] off;

   // Linear scan: is release_reg already among the free slots [head, tail)?
   always_comb begin
      dup = 1'b0;
      off = '0;
      for (int i = 0; i < PHYS_REGS; i++) begin
         off = TAG_W'(i) - head_q;
         if ({1'b0, off} < free_count && mem_q[i] == release_reg)
            dup = 1'b1;
      end
   end

   assign e_empty  = alloc_req & empty;
   assign e_ovf    = release_valid & (release_reg != '0) & full;
   assign e_commit = commit_alloc & (chead_q == head_q);
   assign e_dup    = release_valid & (release_reg != '0) & dup;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         err_q <= 1'b0;
      end else if (e_empty | e_ovf | e_commit | e_dup) begin
         err_q <= 1'b1;
         $display("FREELIST:ERR empty=%0b ovf=%0b commit=%0b dup=%0b tag=%0d",
                  e_empty, e_ovf, e_commit, e_dup, release_reg);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: directed self-checking bench for phys_free_list.
module tb_phys_free_list;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       STALL = 1'b0;
   logic       FLUSH = 1'b0;
   logic       alloc_req = 1'b0;
   logic       rrat_free;
   logic [5:0] rrat_free_reg;
   logic       commit_alloc = 1'b0;
   logic       release_valid = 1'b0;
   logic [5:0] release_reg = '0;
   logic [6:0] free_count;
   logic       halt;
   logic       err;

   int pass_cnt = 0;
   int total    = 0;

   phys_free_list dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .alloc_req(alloc_req), .rrat_free(rrat_free), .rrat_free_reg(rrat_free_reg),
      .commit_alloc(commit_alloc), .release_valid(release_valid),
      .release_reg(release_reg), .free_count(free_count), .halt(halt), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      STALL = 0; FLUSH = 0; alloc_req = 0; commit_alloc = 0;
      release_valid = 0; release_reg = '0;
   endtask

   task automatic do_reset();
      idle();
      RESET = 0;
      #2;
      RESET = 1;
   endtask

   initial begin
      // Reset state
      tick();
      do_reset();
      chk("rst_count", free_count, 32);
      chk("rst_free", rrat_free, 1);
      chk("rst_tag", rrat_free_reg, 32);
      chk("rst_halt", halt, 0);
      chk("rst_err", err, 0);

      // Drain: tags 32..63 in order, then empty
      alloc_req = 1;
      for (int i = 0; i < 32; i++) begin
         chk("drain_tag", rrat_free_reg, 32 + i);
         tick();
      end
      chk("empty_free", rrat_free, 0);
      chk("empty_count", free_count, 0);
      chk("empty_halt", halt, 1);
      tick();
      chk("empty_noop", free_count, 0);

      // Release into empty list with same-cycle allocate: no grant
      release_valid = 1; release_reg = 5;
      tick();
      release_valid = 0; release_reg = 0;
      chk("rel5_free", rrat_free, 1);
      chk("rel5_tag", rrat_free_reg, 5);
      chk("rel5_count", free_count, 1);
      tick();
      alloc_req = 0;
      chk("rel5_drain", free_count, 0);
      chk("rel5_drain_free", rrat_free, 0);

      // 4 allocates, 2 commits, flush -> head 2
      do_reset();
      alloc_req = 1;
      for (int i = 0; i < 4; i++) begin
         chk("fl_tag", rrat_free_reg, 32 + i);
         tick();
      end
      alloc_req = 0; commit_alloc = 1;
      tick(); tick();
      commit_alloc = 0; FLUSH = 1;
      tick();
      FLUSH = 0;
      chk("fl_tag_after", rrat_free_reg, 34);
      chk("fl_count", free_count, 30);

      // 3 allocates, 1 commit, then FLUSH+commit+alloc together -> head 2
      do_reset();
      alloc_req = 1;
      tick(); tick(); tick();
      alloc_req = 0; commit_alloc = 1;
      tick();
      chk("fc_count_pre", free_count, 29);
      FLUSH = 1; commit_alloc = 1; alloc_req = 1;
      tick();
      idle();
      chk("fc_tag", rrat_free_reg, 34);
      chk("fc_count", free_count, 30);
      FLUSH = 1;
      tick();
      idle();
      chk("fc_reflush", rrat_free_reg, 34);

      // STALL blocks allocate but not release; r0 release dropped; overflow dropped
      do_reset();
      alloc_req = 1;
      tick();
      chk("st_count0", free_count, 31);
      STALL = 1; release_valid = 1; release_reg = 0;
      tick();
      chk("st_r0", free_count, 31);
      release_reg = 7;
      tick();
      chk("st_count1", free_count, 32);
      chk("st_tag", rrat_free_reg, 33);
      release_reg = 9;
      tick();
      chk("ovf_count", free_count, 32);
`ifdef FREELIST_CHECK_EN
      chk("ovf_err", err, 1);
      release_valid = 0;
      tick();
      chk("ovf_err_sticky", err, 1);
`else
      chk("err_tied", err, 0);
`endif
      // Drain to confirm order: 33..63, then 7, and no 9
      idle();
      alloc_req = 1;
      for (int i = 0; i < 31; i++) begin
         chk("st_drain", rrat_free_reg, 33 + i);
         tick();
      end
      chk("st_rel7", rrat_free_reg, 7);
      tick();
      alloc_req = 0;
      chk("st_final", free_count, 0);

      // Same-cycle allocate and release on a non-empty list
      do_reset();
      alloc_req = 1;
      tick();
      release_valid = 1; release_reg = 12;
      tick();
      idle();
      chk("ar_count", free_count, 31);
      chk("ar_tag", rrat_free_reg, 34);

      // Asynchronous reset mid-cycle
      #2;
      RESET = 0;
      #1;
      chk("async_count", free_count, 32);
      chk("async_tag", rrat_free_reg, 32);
      chk("async_err", err, 0);
      RESET = 1;

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
